// File: rtl/lut_neuron_prog.sv
//------------------------------------------------------------------------------
// lut_neuron_prog : run-time loadable LogicNets neuron truth table with 1-cycle lookup.
// Optional: LUT_CHECKSUM_EN adds a 16-bit load checksum (prog_cksum / prog_err).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lut_neuron_prog #(
    parameter int IN_BITS      = 8,
    parameter int OUT_BITS     = 2,
    parameter int BEAT_ENTRIES = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             prog_start,
    input  logic [BEAT_ENTRIES*OUT_BITS-1:0] prog_data,
    input  logic                             prog_valid,
    output logic                             prog_ready,
    output logic                             prog_done,
    output logic                             table_valid,
    input  logic [IN_BITS-1:0]               lkp_in,
    input  logic                             lkp_valid,
    output logic [OUT_BITS-1:0]              lkp_out,
    output logic                             lkp_out_valid
`ifdef LUT_CHECKSUM_EN
    ,
    input  logic [15:0]                      prog_cksum,
    output logic                             prog_err
`endif
);

    localparam int DEPTH  = 1 << IN_BITS;
    localparam int BEAT_W = BEAT_ENTRIES * OUT_BITS;
    localparam int NBEATS = DEPTH / BEAT_ENTRIES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               done_next;
    logic               accept;
    logic               last_beat;
    logic               cksum_ok;
    logic [IN_BITS-1:0] base_addr;
    logic [OUT_BITS-1:0] mem [DEPTH];

    // prog_start always wins over a coincident beat
    assign accept      = prog_valid && (state == LOAD) && !prog_start;
    assign last_beat   = accept && (cnt == CNT_W'(NBEATS - 1));
    assign prog_ready  = (state == LOAD);
    assign table_valid = (state == ACTIVE);
    assign base_addr   = IN_BITS'(cnt) * IN_BITS'(BEAT_ENTRIES);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (prog_start) begin
            state_next = LOAD;
            cnt_next   = '0;
        end else if (accept) begin
            cnt_next = last_beat ? '0 : cnt + CNT_W'(1);
            if (last_beat) begin
                done_next  = 1'b1;
                state_next = cksum_ok ? ACTIVE : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            prog_done <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            prog_done <= done_next;
        end
    end

    // Table storage is deliberately not reset; table_valid gates its use
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < BEAT_ENTRIES; k++) begin
                mem[base_addr + IN_BITS'(k)] <= prog_data[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lkp_out_valid <= 1'b0;
            lkp_out       <= '0;
        end else begin
            lkp_out_valid <= lkp_valid && table_valid;
            lkp_out       <= (lkp_valid && table_valid) ? mem[lkp_in] : '0;
        end
    end

`ifdef LUT_CHECKSUM_EN
    logic [15:0] beat16;
    logic [15:0] sum;
    logic [15:0] cksum_ref;

    generate
        if (BEAT_W >= 16) begin : g_cks_trunc
            assign beat16 = prog_data[15:0];
        end else begin : g_cks_zext
            assign beat16 = {{(16-BEAT_W){1'b0}}, prog_data};
        end
    endgenerate

    // Compare including the beat being accepted on this edge
    assign cksum_ok = ((sum + beat16) == cksum_ref);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            cksum_ref <= '0;
            prog_err  <= 1'b0;
        end else if (prog_start) begin
            sum       <= '0;
            cksum_ref <= prog_cksum;
            prog_err  <= 1'b0;
        end else if (accept) begin
            sum <= sum + beat16;
            if (last_beat) begin
                prog_err <= !cksum_ok;
            end
        end
    end
`else
    assign cksum_ok = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_neuron_prog.sv
// Randomized bench for lut_neuron_prog against an array-based table model.
`default_nettype none

module tb_lut_neuron_prog;

    localparam int IN_BITS      = 8;
    localparam int OUT_BITS     = 2;
    localparam int BEAT_ENTRIES = 8;
    localparam int DEPTH        = 256;
    localparam int NBEATS       = 32;

    logic        clk;
    logic        rst_n;
    logic        prog_start;
    logic [15:0] prog_data;
    logic        prog_valid;
    logic        prog_ready;
    logic        prog_done;
    logic        table_valid;
    logic [7:0]  lkp_in;
    logic        lkp_valid;
    logic [1:0]  lkp_out;
    logic        lkp_out_valid;
`ifdef LUT_CHECKSUM_EN
    logic [15:0] prog_cksum;
    logic        prog_err;
`endif

    lut_neuron_prog #(
        .IN_BITS      (IN_BITS),
        .OUT_BITS     (OUT_BITS),
        .BEAT_ENTRIES (BEAT_ENTRIES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .prog_start    (prog_start),
        .prog_data     (prog_data),
        .prog_valid    (prog_valid),
        .prog_ready    (prog_ready),
        .prog_done     (prog_done),
        .table_valid   (table_valid),
        .lkp_in        (lkp_in),
        .lkp_valid     (lkp_valid),
        .lkp_out       (lkp_out),
        .lkp_out_valid (lkp_out_valid)
`ifdef LUT_CHECKSUM_EN
        ,
        .prog_cksum    (prog_cksum),
        .prog_err      (prog_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the table as an array plus load progress
    logic [1:0]  m_mem [DEPTH];
    bit          m_loading;
    bit          m_tv;
    bit          m_done;
    int          m_beats;
    int          m_acc_total;
    logic [15:0] m_sum;
    logic [15:0] m_ck;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 0;
        m_tv      = 0;
        m_done    = 0;
        m_beats   = 0;
        m_sum     = '0;
        m_ck      = '0;
        m_err     = 0;
    endtask

    task automatic step(input bit start, input bit pv, input logic [15:0] pd,
                        input bit lv, input logic [7:0] la);
        bit         acc;
        bit         exp_lv;
        logic [1:0] exp_lo;
        prog_start = start;
        prog_valid = pv;
        prog_data  = pd;
        lkp_valid  = lv;
        lkp_in     = la;
        acc    = pv && m_loading && !start;
        exp_lv = lv && m_tv;
        exp_lo = exp_lv ? m_mem[la] : 2'b00;
        @(posedge clk);
        #1;
        m_done = 0;
        if (start) begin
            m_loading = 1;
            m_tv      = 0;
            m_beats   = 0;
            m_sum     = '0;
            m_err     = 0;
`ifdef LUT_CHECKSUM_EN
            m_ck      = prog_cksum;
`endif
        end else if (acc) begin
            for (int k = 0; k < BEAT_ENTRIES; k++) begin
                m_mem[m_beats*BEAT_ENTRIES + k] = pd[k*OUT_BITS +: OUT_BITS];
            end
            m_sum = m_sum + pd;
            m_beats++;
            m_acc_total++;
            if (m_beats == NBEATS) begin
                m_loading = 0;
                m_done    = 1;
                m_beats   = 0;
                m_tv      = 1;
`ifdef LUT_CHECKSUM_EN
                if (m_sum != m_ck) begin
                    m_tv  = 0;
                    m_err = 1;
                end
`endif
            end
        end
        check("lkp_out_valid", 32'(lkp_out_valid), 32'(exp_lv));
        check("lkp_out", 32'(lkp_out), 32'(exp_lo));
        check("prog_ready", 32'(prog_ready), 32'(m_loading));
        check("table_valid", 32'(table_valid), 32'(m_tv));
        check("prog_done", 32'(prog_done), 32'(m_done));
`ifdef LUT_CHECKSUM_EN
        check("prog_err", 32'(prog_err), 32'(m_err));
`endif
    endtask

    // mode 0: 16'hE4E4, 1: random, 2: zero. Stops at load end or after max_beats accepted.
    task automatic load(input bit do_start, input int mode, input int gap_pct, input int max_beats);
        int          first;
        int          budget;
        bit          pv;
        logic [15:0] pd;
        if (do_start) step(1'b1, 1'b0, 16'($urandom), 1'($urandom), 8'($urandom));
        first  = m_acc_total;
        budget = 0;
        while (!m_done && (m_acc_total - first) < max_beats && budget < 2000) begin
            pv = ($urandom_range(99) >= gap_pct);
            pd = (mode == 0) ? 16'hE4E4 : (mode == 1) ? 16'($urandom) : 16'h0000;
            step(1'b0, pv, pd, 1'($urandom), 8'($urandom));
            budget++;
        end
        if (budget >= 2000) check("load_timeout", 32'd1, 32'd0);
    endtask

    task automatic lookups(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'($urandom), 16'($urandom), 1'($urandom_range(3) != 0), 8'($urandom));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_data  = '0;
        lkp_valid  = 1'b0;
        lkp_in     = '0;
`ifdef LUT_CHECKSUM_EN
        prog_cksum = 16'h0000;
`endif
        m_acc_total = 0;
        model_reset();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prog_ready", 32'(prog_ready), 32'd0);
        check("rst_prog_done", 32'(prog_done), 32'd0);
        check("rst_table_valid", 32'(table_valid), 32'd0);
        check("rst_lkp_out", 32'(lkp_out), 32'd0);
        check("rst_lkp_out_valid", 32'(lkp_out_valid), 32'd0);
        rst_n = 1'b1;

        // Lookups before any load are dropped
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 8'h05);

`ifdef LUT_CHECKSUM_EN
        prog_cksum = 16'h9C80;
`endif
        load(1'b1, 0, 0, NBEATS);
        step(1'b0, 1'b0, 16'h0, 1'b1, 8'h05);
        check("e4_addr05", 32'(lkp_out), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 8'hFF);
        check("e4_addrFF", 32'(lkp_out), 32'd3);
        lookups(20);

`ifdef LUT_CHECKSUM_EN
        prog_cksum = 16'h0000;
        load(1'b1, 0, 0, NBEATS);
        check("cks_bad_err", 32'(prog_err), 32'd1);
        check("cks_bad_tv", 32'(table_valid), 32'd0);
        lookups(10);
`endif

        // Random table with random valid gaps; checksum computed by the model
`ifdef LUT_CHECKSUM_EN
        prog_cksum = 16'h0000;
`endif
        load(1'b1, 1, 50, NBEATS);
        lookups(40);

        // Restart mid-load with a coincident valid beat
        load(1'b1, 1, 0, 10);
        step(1'b1, 1'b1, 16'($urandom), 1'b1, 8'($urandom));
        load(1'b0, 1, 30, NBEATS);
        lookups(40);

        // Asynchronous reset mid-load
        load(1'b1, 1, 0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_prog_ready", 32'(prog_ready), 32'd0);
        check("arst_table_valid", 32'(table_valid), 32'd0);
        check("arst_prog_done", 32'(prog_done), 32'd0);
        check("arst_lkp_out_valid", 32'(lkp_out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load(1'b1, 2, 20, NBEATS);
        for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 16'h0, 1'b1, 8'(a));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
